// File: rtl/led_flasher_multi.sv
`default_nettype none
// ============================================================================
// Module   : led_flasher_multi
// Brief    : Multi-channel LED flasher. A shared prescaler produces a
//            half-period tick. Each channel runs independently in OFF, ON,
//            BLINK or counted BURST mode, configured via a one-cycle write
//            port. BURST completion is flagged with a one-cycle done pulse.
// Options  : TICK_RESYNC_EN - an accepted config write also clears the
//            prescaler, so the first half-period after a write is always
//            exactly CNT_MAX+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module led_flasher_multi #(
  parameter int          CH      = 4,
  parameter logic [31:0] CNT_MAX = 32'd24_999_999,
  parameter int          CNT_W   = 32,
  parameter int          BW      = 8,
  localparam int         CH_W    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [1:0]      cfg_mode,
  input  logic [BW-1:0]   cfg_cnt,
  output logic [CH-1:0]   led,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   done
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
  // One extra bit so that CH=2^CH_W is representable for the range check.
  localparam logic [CH_W:0]    CH_LIM  = (CH_W + 1)'(CH);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             wr_ok;
  logic             cnt_clr;

  assign tick  = (cnt == CNT_TOP);
  assign wr_ok = cfg_we && ({1'b0, cfg_ch} < CH_LIM);

`ifdef TICK_RESYNC_EN
  assign cnt_clr = wr_ok;
`else
  assign cnt_clr = 1'b0;
`endif

  // Free-running prescaler, 0..CNT_MAX, optionally re-phased by config writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);

    mode_t         mode;
    logic [BW-1:0] burst_left;
    logic          led_q;
    logic          done_q;
    logic          sel;

    assign sel = wr_ok && (cfg_ch == IDX);

    // Per-channel mode machine; a write to this channel overrides any tick.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode       <= MODE_OFF;
        burst_left <= '0;
        led_q      <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (sel) begin
          mode       <= mode_t'(cfg_mode);
          led_q      <= (cfg_mode == MODE_ON);
          burst_left <= cfg_cnt;
        end else begin
          case (mode)
            MODE_OFF:   led_q <= 1'b0;
            MODE_ON:    led_q <= 1'b1;
            MODE_BLINK: begin
              if (tick) begin
                led_q <= ~led_q;
              end
            end
            MODE_BURST: begin
              // A zero-length burst completes on the first cycle without a tick.
              if (burst_left == '0 && !led_q) begin
                mode   <= MODE_OFF;
                done_q <= 1'b1;
              end else if (tick) begin
                if (led_q) begin
                  led_q      <= 1'b0;
                  burst_left <= burst_left - BW'(1);
                  if (burst_left == BW'(1)) begin
                    mode   <= MODE_OFF;
                    done_q <= 1'b1;
                  end
                end else begin
                  led_q <= 1'b1;
                end
              end
            end
          endcase
        end
      end
    end

    assign led[i]  = led_q;
    assign done[i] = done_q;
    assign busy[i] = (mode == MODE_BURST);
  end

endmodule
`default_nettype wire

// File: tb/tb_led_flasher_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_flasher_multi
// Brief    : Self-checking bench for led_flasher_multi: directed vector table,
//            reset / prescaler-phase sequence, and randomized traffic against
//            a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_flasher_multi;

  localparam int CH      = 5;
  localparam int CNT_MAX = 3;
  localparam int BW      = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [2:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [BW-1:0] cfg_cnt;
  logic [CH-1:0] led;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;

  int total = 0;
  int bad   = 0;

  led_flasher_multi #(
    .CH      (CH),
    .CNT_MAX (32'd3),
    .CNT_W   (8),
    .BW      (BW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_cnt  (cfg_cnt),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Modes: 0 OFF, 1 ON, 2 BLINK, 3 BURST. Pulses remaining counted as an int.
  int m_phase;
  int m_mode [CH];
  int m_lit  [CH];
  int m_left [CH];
  int m_done [CH];

  function automatic void model_reset();
    m_phase = 0;
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_lit[c] = 0; m_left[c] = 0; m_done[c] = 0;
    end
  endfunction

  function automatic void model_step(input bit we, input int ch, input int md, input int n);
    bit tick = (m_phase == CNT_MAX);
    bit ok   = we && (ch < CH);
    for (int c = 0; c < CH; c++) begin
      m_done[c] = 0;
      if (ok && ch == c) begin
        m_mode[c] = md;
        m_lit[c]  = (md == 1) ? 1 : 0;
        m_left[c] = n;
      end else if (m_mode[c] == 1) begin
        m_lit[c] = 1;
      end else if (m_mode[c] == 0) begin
        m_lit[c] = 0;
      end else if (m_mode[c] == 2) begin
        if (tick) m_lit[c] = 1 - m_lit[c];
      end else if (m_left[c] == 0 && m_lit[c] == 0) begin
        m_mode[c] = 0;
        m_done[c] = 1;
      end else if (tick) begin
        if (m_lit[c] == 1) begin
          m_lit[c]  = 0;
          m_left[c] = m_left[c] - 1;
          if (m_left[c] == 0) begin
            m_mode[c] = 0;
            m_done[c] = 1;
          end
        end else begin
          m_lit[c] = 1;
        end
      end
    end
    m_phase = (m_phase + 1) % (CNT_MAX + 1);
`ifdef TICK_RESYNC_EN
    if (ok) m_phase = 0;
`endif
  endfunction

  function automatic logic [CH-1:0] m_vec(input int which);
    logic [CH-1:0] v = '0;
    for (int c = 0; c < CH; c++) begin
      case (which)
        0:       v[c] = (m_lit[c] != 0);
        1:       v[c] = (m_mode[c] == 3);
        default: v[c] = (m_done[c] != 0);
      endcase
    end
    return v;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          we;
    logic [2:0]    ch;
    logic [1:0]    mode;
    logic [BW-1:0] cnt;
    logic [CH-1:0] e_led;
    logic [CH-1:0] e_busy;
    logic [CH-1:0] e_done;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic we, input logic [2:0] ch, input logic [1:0] md,
                              input logic [BW-1:0] n, input logic [CH-1:0] l,
                              input logic [CH-1:0] b, input logic [CH-1:0] d);
    vec_t v;
    v.we = we; v.ch = ch; v.mode = md; v.cnt = n;
    v.e_led = l; v.e_busy = b; v.e_done = d;
    return v;
  endfunction

  int n_wait;
  int exp_wait;

  initial begin
    // Row k is applied in the cycle where the prescaler equals k mod 4.
    // Accepted writes occur only on tick cycles, so the prescaler phase is
    // identical with or without the resync option.
    tbl[0]  = mk(0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[1]  = mk(1, 5, 1, 0, 5'b00000, 5'b00000, 5'b00000); // out-of-range channel
    tbl[2]  = mk(0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[3]  = mk(1, 1, 2, 0, 5'b00000, 5'b00000, 5'b00000); // BLINK on tick: no toggle
    tbl[4]  = mk(0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[5]  = mk(0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[6]  = mk(0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000);
    tbl[7]  = mk(1, 2, 3, 2, 5'b00010, 5'b00100, 5'b00000); // BURST x2 on ch2
    tbl[8]  = mk(0, 0, 0, 0, 5'b00010, 5'b00100, 5'b00000);
    tbl[9]  = mk(0, 0, 0, 0, 5'b00010, 5'b00100, 5'b00000);
    tbl[10] = mk(0, 0, 0, 0, 5'b00010, 5'b00100, 5'b00000);
    tbl[11] = mk(1, 0, 3, 0, 5'b00100, 5'b00101, 5'b00000); // BURST x0 on ch0
    tbl[12] = mk(0, 0, 0, 0, 5'b00100, 5'b00100, 5'b00001);
    tbl[13] = mk(0, 0, 0, 0, 5'b00100, 5'b00100, 5'b00000);
    tbl[14] = mk(0, 0, 0, 0, 5'b00100, 5'b00100, 5'b00000);
    tbl[15] = mk(1, 3, 1, 0, 5'b01010, 5'b00100, 5'b00000); // ON on tick cycle
    tbl[16] = mk(0, 0, 0, 0, 5'b01010, 5'b00100, 5'b00000);
    tbl[17] = mk(0, 0, 0, 0, 5'b01010, 5'b00100, 5'b00000);
    tbl[18] = mk(0, 0, 0, 0, 5'b01010, 5'b00100, 5'b00000);
    tbl[19] = mk(0, 0, 0, 0, 5'b01100, 5'b00100, 5'b00000);
    tbl[20] = mk(0, 0, 0, 0, 5'b01100, 5'b00100, 5'b00000);
    tbl[21] = mk(0, 0, 0, 0, 5'b01100, 5'b00100, 5'b00000);
    tbl[22] = mk(0, 0, 0, 0, 5'b01100, 5'b00100, 5'b00000);
    tbl[23] = mk(0, 0, 0, 0, 5'b01010, 5'b00000, 5'b00100); // burst complete
    tbl[24] = mk(0, 0, 0, 0, 5'b01010, 5'b00000, 5'b00000);
    tbl[25] = mk(0, 0, 0, 0, 5'b01010, 5'b00000, 5'b00000);
    tbl[26] = mk(0, 0, 0, 0, 5'b01010, 5'b00000, 5'b00000);
    tbl[27] = mk(1, 2, 3, 3, 5'b01000, 5'b00100, 5'b00000);
    tbl[28] = mk(0, 0, 0, 0, 5'b01000, 5'b00100, 5'b00000);
    tbl[29] = mk(0, 0, 0, 0, 5'b01000, 5'b00100, 5'b00000);
    tbl[30] = mk(0, 0, 0, 0, 5'b01000, 5'b00100, 5'b00000);
    tbl[31] = mk(1, 2, 1, 0, 5'b01110, 5'b00000, 5'b00000); // abort burst, no done
    tbl[32] = mk(0, 0, 0, 0, 5'b01110, 5'b00000, 5'b00000);

    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_led", led, '0);
    check("reset_busy", busy, '0);
    check("reset_done", done, '0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      cfg_we = tbl[k].we; cfg_ch = tbl[k].ch; cfg_mode = tbl[k].mode; cfg_cnt = tbl[k].cnt;
      step();
      cfg_we = 1'b0;
      check($sformatf("vec%0d_led", k), led, tbl[k].e_led);
      check($sformatf("vec%0d_busy", k), busy, tbl[k].e_busy);
      check($sformatf("vec%0d_done", k), done, tbl[k].e_done);
    end

    // Asynchronous reset mid-run: outputs clear without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", led, '0);
    check("async_rst_busy", busy, '0);
    check("async_rst_done", done, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Prescaler restarts at 0; write BLINK at prescaler=2 and time the first toggle.
    step();
    step();
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_mode = 2'b10; cfg_cnt = '0;
    step();
    cfg_we = 1'b0;
    n_wait = 1;
    while (!led[1] && n_wait < 20) begin
      step();
      n_wait++;
    end
`ifdef TICK_RESYNC_EN
    exp_wait = 5;
`else
    exp_wait = 2;
`endif
    check_int("first_toggle_edges", n_wait, exp_wait);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    for (int t = 0; t < 600; t++) begin
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_ch   = 3'($urandom_range(0, 7));
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_cnt  = BW'($urandom_range(0, 3));
      step();
      model_step(cfg_we, int'(cfg_ch), int'(cfg_mode), int'(cfg_cnt));
      check($sformatf("rand%0d_led", t), led, m_vec(0));
      check($sformatf("rand%0d_busy", t), busy, m_vec(1));
      check($sformatf("rand%0d_done", t), done, m_vec(2));
    end
    cfg_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
